// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage next-PC generator with a direct-mapped BTB.
// Looks up the current PC in the BTB and combines a hit with the
// predictor's predict_taken to choose the next fetch address. It consumes
// resolved branches from EX, forwards them to the predictor, and redirects
// fetch with a flush on a mispredict.
// Optional feature macro: FETCH_PERF_CNT_EN (resolved-branch and mispredict
// counters); when undefined both counter ports are tied to zero.
module fetch_pc_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            predict_taken,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            pred_taken_out,
  output logic [XLEN-1:0] pred_target_out,
  input  logic            ex_branch_valid,
  input  logic [XLEN-1:0] ex_branch_pc,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            branch_request,
  output logic            branch_taken,
  output logic            flush,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [XLEN-3:0]        btb_target [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] wr_idx;
  logic             hit;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  next_pc;
  logic             mispredict;

  // BTB lookup on the current fetch PC and prediction outputs
  always_comb begin
    lk_idx          = pc_out[IDX_W+1:2];
    lk_tag          = pc_out[XLEN-1:IDX_W+2];
    wr_idx          = ex_branch_pc[IDX_W+1:2];
    pc_plus4        = pc_out + XLEN'(4);
    hit             = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    pred_taken_out  = hit && predict_taken;
    pred_target_out = hit ? {btb_target[lk_idx], 2'b00} : pc_plus4;
  end

  // Branch resolution: predictor update pass-through and mispredict detect
  always_comb begin
    branch_request = ex_branch_valid;
    branch_taken   = ex_branch_taken;
    mispredict     = ex_branch_valid &&
                     ((ex_branch_taken != ex_pred_taken) ||
                      (ex_branch_taken && ex_pred_taken &&
                       (ex_branch_target != ex_pred_target)));
    flush          = mispredict;
  end

  // Next-PC selection; the PC also holds during the first cycle out of
  // reset so that RESET_PC itself is presented as a valid fetch
  always_comb begin
    next_pc = pc_plus4;
    if (mispredict)
      next_pc = ex_branch_taken ? ex_branch_target : (ex_branch_pc + XLEN'(4));
    else if (stall || !pc_valid)
      next_pc = pc_out;
    else if (pred_taken_out)
      next_pc = pred_target_out;
  end

  // PC and fetch-valid registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_out   <= RESET_PC;
      pc_valid <= 1'b0;
    end else begin
      pc_out   <= next_pc;
      pc_valid <= 1'b1;
    end
  end

  // BTB valid bits: set on every taken resolution, cleared by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      btb_valid <= '0;
    else if (ex_branch_valid && ex_branch_taken)
      btb_valid[wr_idx] <= 1'b1;
  end

  // BTB tag/target storage; qualified by the valid bits, so no reset needed
  always_ff @(posedge clk) begin
    if (ex_branch_valid && ex_branch_taken) begin
      btb_tag[wr_idx]    <= ex_branch_pc[XLEN-1:IDX_W+2];
      btb_target[wr_idx] <= ex_branch_target[XLEN-1:2];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating resolved-branch and mispredict counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (ex_branch_valid && (branch_count != '1))
        branch_count <= branch_count + 32'd1;
      if (mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`else
  // Counters disabled: constant zero outputs
  always_comb begin
    branch_count     = '0;
    mispredict_count = '0;
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed bench for fetch_pc_unit (RESET_PC = 0x100,
// 16-entry BTB). Expected next-PC values are queued when each step is driven
// and popped after the clock edge that should produce them.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, predict_taken;
  logic [31:0] pc_out;
  logic        pc_valid, pred_taken_out;
  logic [31:0] pred_target_out;
  logic        ex_branch_valid, ex_branch_taken, ex_pred_taken;
  logic [31:0] ex_branch_pc, ex_branch_target, ex_pred_target;
  logic        branch_request, branch_taken, flush;
  logic [31:0] branch_count, mispredict_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned exp_br = 0;
  int unsigned exp_mp = 0;
  logic [31:0] sb_q[$];

  fetch_pc_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0100),
    .BTB_ENTRIES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .predict_taken(predict_taken),
    .pc_out(pc_out), .pc_valid(pc_valid), .pred_taken_out(pred_taken_out),
    .pred_target_out(pred_target_out), .ex_branch_valid(ex_branch_valid),
    .ex_branch_pc(ex_branch_pc), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .branch_request(branch_request),
    .branch_taken(branch_taken), .flush(flush), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_branch_count"}, branch_count, exp_br);
    chk({tag, "_mispredict_count"}, mispredict_count, exp_mp);
`else
    chk({tag, "_branch_count"}, branch_count, 32'h0);
    chk({tag, "_mispredict_count"}, mispredict_count, 32'h0);
`endif
  endtask

  // One clock: drive, check combinational outputs, queue next PC, clock, pop
  task automatic step(input string tag,
                      input logic stl, input logic pt,
                      input logic ev, input logic [31:0] epc, input logic et,
                      input logic [31:0] etgt, input logic ept, input logic [31:0] eptgt,
                      input logic xflush, input logic xpt, input logic [31:0] xptgt,
                      input logic [31:0] xnext);
    logic [31:0] exp_pc;
    stall = stl; predict_taken = pt;
    ex_branch_valid = ev; ex_branch_pc = epc; ex_branch_taken = et;
    ex_branch_target = etgt; ex_pred_taken = ept; ex_pred_target = eptgt;
    #1;
    chk({tag, "_flush"}, {31'b0, flush}, {31'b0, xflush});
    chk({tag, "_branch_request"}, {31'b0, branch_request}, {31'b0, ev});
    chk({tag, "_branch_taken"}, {31'b0, branch_taken}, {31'b0, et});
    chk({tag, "_pred_taken_out"}, {31'b0, pred_taken_out}, {31'b0, xpt});
    chk({tag, "_pred_target_out"}, pred_target_out, xptgt);
    sb_q.push_back(xnext);
    if (ev) exp_br++;
    if (xflush) exp_mp++;
    @(posedge clk);
    #1;
    ex_branch_valid = 1'b0; ex_branch_taken = 1'b0; ex_pred_taken = 1'b0;
    if (sb_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'h1, 32'h0);
    end else begin
      exp_pc = sb_q.pop_front();
      chk({tag, "_pc_out"}, pc_out, exp_pc);
    end
    chk({tag, "_pc_valid"}, {31'b0, pc_valid}, 32'h1);
    check_counters(tag);
  endtask

  // Plain fetch cycle with no branch resolving in EX
  task automatic fetch(input string tag, input logic stl, input logic pt,
                       input logic xpt, input logic [31:0] xptgt, input logic [31:0] xnext);
    step(tag, stl, pt, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, xpt, xptgt, xnext);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; predict_taken = 1'b0;
    ex_branch_valid = 1'b0; ex_branch_pc = '0; ex_branch_taken = 1'b0;
    ex_branch_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    #7;
    chk("rst_pc", pc_out, 32'h100);
    chk("rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    check_counters("rst");
    reset_n = 1'b1;
    #1;

    // Reset release: RESET_PC becomes valid, then sequential fetch
    fetch("first", 1'b0, 1'b0, 1'b0, 32'h104, 32'h100);
    fetch("seq1",  1'b0, 1'b0, 1'b0, 32'h104, 32'h104);
    fetch("seq2",  1'b0, 1'b0, 1'b0, 32'h108, 32'h108);
    // Taken branch at 0x108 predicted not-taken: flush, redirect, BTB[2] fill
    step("mp_taken", 1'b0, 1'b0, 1'b1, 32'h108, 1'b1, 32'h200, 1'b0, 32'h0,
         1'b1, 1'b0, 32'h10C, 32'h200);
    // Wrong target (0x180 -> 0x108); writes BTB[0] while 0x200 looks up BTB[0]:
    // lookup must still see the old, invalid entry
    step("mp_target", 1'b0, 1'b1, 1'b1, 32'h180, 1'b1, 32'h108, 1'b1, 32'h104,
         1'b1, 1'b0, 32'h204, 32'h108);
    // BTB hit with predict_taken steers to stored target
    fetch("hit_taken", 1'b0, 1'b1, 1'b1, 32'h200, 32'h200);
    // Aliased index 0 holds 0x180's tag: miss at 0x200
    step("mp_nt_104", 1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b1, 32'h0,
         1'b1, 1'b0, 32'h204, 32'h108);
    // Hit but predictor says not-taken: sequential
    fetch("hit_nt", 1'b0, 1'b0, 1'b0, 32'h200, 32'h10C);
    // 0x108 resolves not-taken after predicted taken: redirect to 0x10C
    step("mp_nt_108", 1'b0, 1'b0, 1'b1, 32'h108, 1'b0, 32'h0, 1'b1, 32'h200,
         1'b1, 1'b0, 32'h110, 32'h10C);
    // 0x100 taken to 0x108 overwrites alias at index 0
    step("mp_100", 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h108, 1'b0, 32'h0,
         1'b1, 1'b0, 32'h110, 32'h108);
    // BTB entry for 0x108 untouched by the not-taken resolution
    fetch("btb_kept", 1'b0, 1'b1, 1'b1, 32'h200, 32'h200);
    step("mp_to_120", 1'b0, 1'b0, 1'b1, 32'h11C, 1'b1, 32'h120, 1'b0, 32'h0,
         1'b1, 1'b0, 32'h204, 32'h120);
    // Stall holds the PC for three cycles
    fetch("stall1", 1'b1, 1'b0, 1'b0, 32'h124, 32'h120);
    fetch("stall2", 1'b1, 1'b0, 1'b0, 32'h124, 32'h120);
    fetch("stall3", 1'b1, 1'b0, 1'b0, 32'h124, 32'h120);
    // Mispredict overrides stall
    step("mp_stall", 1'b1, 1'b0, 1'b1, 32'h130, 1'b1, 32'h300, 1'b0, 32'h0,
         1'b1, 1'b0, 32'h124, 32'h300);
    // Correct taken prediction: update strobe but no flush
    step("correct", 1'b0, 1'b0, 1'b1, 32'h130, 1'b1, 32'h300, 1'b1, 32'h300,
         1'b0, 1'b0, 32'h304, 32'h304);
    // Redirect uses the raw target including low bits
    step("raw_tgt", 1'b0, 1'b0, 1'b1, 32'h140, 1'b1, 32'h403, 1'b0, 32'h0,
         1'b1, 1'b0, 32'h308, 32'h403);
    // Wrap-around: 0xFFFF_FFFC + 4 = 0
    step("to_top", 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,
         1'b1, 1'b0, 32'h407, 32'hFFFF_FFFC);
    fetch("wrap", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Asynchronous reset mid-operation
    reset_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc_out, 32'h100);
    chk("mid_rst_valid", {31'b0, pc_valid}, 32'h0);
    exp_br = 0; exp_mp = 0;
    check_counters("mid_rst");
    #1;
    reset_n = 1'b1;
    fetch("r_first", 1'b0, 1'b0, 1'b0, 32'h104, 32'h100);
    fetch("r_seq1",  1'b0, 1'b0, 1'b0, 32'h104, 32'h104);
    fetch("r_seq2",  1'b0, 1'b0, 1'b0, 32'h108, 32'h108);
    // BTB valids were cleared: 0x108 now misses even with predict_taken
    fetch("r_miss",  1'b0, 1'b1, 1'b0, 32'h10C, 32'h10C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout pc_out=%h", pc_out);
    $fatal(1, "timeout");
  end

endmodule
